bcd_timer_counter: RTL
======================

Name: bcd_timer_counter

Overview:
Parametrised multi-digit BCD counter for the microwave timer-input path. It generalises the single-digit 0–9 counter to DIGITS cascaded decades. It adds:
- up/down direction;
- parallel load for preset times;
- count enable;
- a selectable recycling (wrap) or non-recycling (saturate) mode, chosen by parameter.

It sits between the keypad/timer-entry logic and the display/countdown controller.

Parameters:
DIGITS, 2, number of BCD decades (1..8); q width is 4*DIGITS.
RECYCLE, 1, 1 = wrap at the bound (99..9 -> 0 up, 0 -> 99..9 down); 0 = hold at the bound (non-recycling).

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; one clock; reset is synchronous and active-low
en  input  1  count enable; one step per clk while high
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load strobe
load_val  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0]
q  output  4*DIGITS  registered BCD count, digit 0 in bits [3:0]
tc  output  1  registered terminal-count pulse
sat  output  1  registered; high while held at a bound (RECYCLE=0 only)
zero  output  1  combinational; high when q == 0

Behaviour:
- All state updates on the rising edge of clk. Priority: rst low > load > en > hold.
- Reset (rst==0 at an edge):
  - q=0, tc=0, sat=0; zero=1.
  - Reset held low keeps q at 0 regardless of en/load.
  - Reset asserted mid-count aborts the count at the next edge with no tc.
- Load (rst==1, load==1):
  - q <= load_val, tc <= 0, sat <= 0. en is ignored in that cycle.
  - Any load_val digit > 9 is clamped to 9 per digit.
  - Load latency is 1 cycle.
- Up step (en==1, up_dn==1):
  - Digit 0 increments.
  - A digit at 9 goes to 0 and carries into the next digit; carries ripple combinationally within the same cycle.
  - Non-terminal step: tc <= 0.
- Down step (en==1, up_dn==0):
  - Digit 0 decrements.
  - A digit at 0 goes to 9 and borrows from the next digit.
  - Non-terminal step: tc <= 0.
- Bounds: MAX is all digits = 9 (e.g. 99 for DIGITS=2); MIN is 0.
- RECYCLE=1:
  - Up from MAX -> q=0, tc=1 for exactly one cycle (registered with q).
  - Down from 0 -> q=MAX, tc=1 for one cycle.
  - sat is always 0.
- RECYCLE=0:
  - Up at MAX, or down at 0 -> q holds, sat <= 1.
  - tc <= 1 only on the step that first reaches the bound, i.e. the step producing q==MAX (up) or q==0 (down).
  - Further steps at the bound leave tc=0 and sat=1.
  - sat clears on any step away from the bound, on load, or on reset.
- en==0 (no load): q, sat hold; tc <= 0.
- Direction change is allowed on any cycle with no penalty. up_dn is sampled only when en==1.
- tc is never high for two consecutive cycles unless two consecutive wraps occur (RECYCLE=1, DIGITS=1 cannot do this; only alternating bounds can).
- zero is derived from registered q only; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset/hold, DIGITS=2, RECYCLE=1: rst=0 for 5 clocks with en=1 -> q=00, tc=0, sat=0, zero=1 each cycle. Release rst and count up 18 clocks -> q=18; check digit0 follows i%10 with carry at 09->10.
- Up wrap, RECYCLE=1: load 97, then 3 up steps -> q=98, 99, 00. tc=1 only in the cycle q=00; zero=1 there.
- Down wrap and borrow, RECYCLE=1: load 10, then 2 down steps -> q=09, 08. Load 00, then 1 down step -> q=99, tc=1.
- Saturation, RECYCLE=0: load 02 and step down 4 times -> q=01, 00, 00, 00. tc=1 only at the first 00; sat=1 from the first 00 onward. One up step -> q=01, sat=0.
- Priority and clamping: load=1 with en=1 and load_val=0xA5 -> q=95 (clamped) with no step taken. rst=0 with load=1 at the same edge -> q=00.
- Mid-operation reset and enable gating:
  - Count to 37, then rst=0 for one edge -> q=00, tc=0.
  - Then en=0 for 4 clocks -> q stays 00.
  - Toggle up_dn every cycle with en=1 -> q alternates 01/00 (down from 01 gives 00, no tc; down from 00 wraps per mode).

Source files
------------

// File: rtl/bcd_timer_counter.sv
// bcd_timer_counter: DIGITS-decade up/down BCD counter with clamped parallel load, enable,
// terminal-count pulse and wrap or saturate behaviour at the bounds.
module bcd_timer_counter #(
   parameter int DIGITS  = 2,
   parameter bit RECYCLE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   q,
   output logic                  tc,
   output logic                  sat,
   output logic                  zero
);
   localparam int W = 4*DIGITS;
   localparam logic [W-1:0] MAX = {DIGITS{4'h9}};
   logic [W-1:0] clamped, stepped, target;
   logic [3:0] d;
   logic ripple, hit;
   // ripple ends high only when every digit sat at the bound, i.e. q is at the bound itself
   always_comb begin
      clamped = '0;
      stepped = '0;
      ripple = 1'b1;
      d = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = load_val[4*i +: 4];
         clamped[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
         d = q[4*i +: 4];
         stepped[4*i +: 4] = !ripple ? d :
                             up_dn ? ((d == 4'd9) ? 4'd0 : d + 4'd1) :
                                     ((d == 4'd0) ? 4'd9 : d - 4'd1);
         ripple = ripple & (up_dn ? (d == 4'd9) : (d == 4'd0));
      end
      target = up_dn ? MAX : '0;
      hit = (stepped == target);
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         q   <= '0;
         tc  <= 1'b0;
         sat <= 1'b0;
      end else if (load) begin
         q   <= clamped;
         tc  <= 1'b0;
         sat <= 1'b0;
      end else if (en) begin
         q   <= (ripple && !RECYCLE) ? q : stepped;
         tc  <= RECYCLE ? ripple : (!ripple && hit);
         sat <= !RECYCLE && (ripple || hit);
      end else begin
         tc  <= 1'b0;
      end
   end
   assign zero = (q == '0);
endmodule
